// File: rtl/regfile_scoreboard.sv
// Integer register file: two combinational read ports, one write port, write-to-read bypass,
// per-register pending bits, and a sequential clear engine that zeroes the array.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   rd_value,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  output logic [XLEN-1:0]   rs1_value,
  output logic              rs1_pending,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   rs2_value,
  output logic              rs2_pending
);

  localparam int unsigned       NRegs   = 1 << ADDR_W;
  localparam bit                ZeroEn  = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NRegs - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              clear_busy_q;
  logic [NRegs-1:0]  pending_q;
  logic [XLEN-1:0]   regs_q [NRegs];

  logic idle;
  logic wr_qual;
  logic issue_qual;

  assign idle       = (state_q == StIdle);
  assign wr_qual    = idle && wr_en && !(ZeroEn && (rd == '0));
  assign issue_qual = idle && issue_en && !(ZeroEn && (issue_rd == '0));
  assign clear_busy = clear_busy_q;

  // Clear engine; idx wraps to 0 naturally after the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StClear;
      clr_idx_q    <= '0;
      clear_busy_q <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == LastIdx) begin
            state_q      <= StIdle;
            clear_busy_q <= 1'b0;
          end
        end
        StIdle: begin
          if (clear_req) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= StClear;
          clr_idx_q    <= '0;
          clear_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Issue is applied after the write so a same-edge issue leaves the entry pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else if (idle) begin
      if (clear_req) begin
        pending_q <= '0;
      end else begin
        if (wr_qual) begin
          pending_q[rd] <= 1'b0;
        end
        if (issue_qual) begin
          pending_q[issue_rd] <= 1'b1;
        end
      end
    end
  end

  // Array has no reset; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_qual) begin
      regs_q[rd] <= rd_value;
    end
  end

  always_comb begin
    rs1_value   = '0;
    rs1_pending = 1'b0;
    if (idle && !(ZeroEn && (rs1 == '0))) begin
      if (wr_qual && (rd == rs1)) begin
        rs1_value = rd_value;
      end else begin
        rs1_value   = regs_q[rs1];
        rs1_pending = pending_q[rs1];
      end
    end
  end

  always_comb begin
    rs2_value   = '0;
    rs2_pending = 1'b0;
    if (idle && !(ZeroEn && (rs2 == '0))) begin
      if (wr_qual && (rd == rs2)) begin
        rs2_value = rd_value;
      end else begin
        rs2_value   = regs_q[rs2];
        rs2_pending = pending_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: clear engine, reads/writes, bypass, scoreboard.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        clear_busy;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [31:0] rs1_value;
  logic        rs1_pending;
  logic [4:0]  rs2;
  logic [31:0] rs2_value;
  logic        rs2_pending;

  int checks;
  int failures;
  int n;

  regfile_scoreboard #(
    .XLEN    (32),
    .ADDR_W  (5),
    .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .wr_en      (wr_en),
    .rd         (rd),
    .rd_value   (rd_value),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs1_value  (rs1_value),
    .rs1_pending(rs1_pending),
    .rs2        (rs2),
    .rs2_value  (rs2_value),
    .rs2_pending(rs2_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts rising edges until clear_busy drops, with a bound.
  task automatic count_busy(inout int cnt);
    while (clear_busy && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    clear_req = 1'b0;
    wr_en     = 1'b0;
    rd        = '0;
    rd_value  = '0;
    issue_en  = 1'b0;
    issue_rd  = '0;
    rs1       = 5'd3;
    rs2       = 5'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", {31'd0, clear_busy}, 32'd1);
    check_eq("rst_rs1_val", rs1_value, 32'd0);
    check_eq("rst_rs1_pend", {31'd0, rs1_pending}, 32'd0);

    // Write/issue to x3 held during clear must be ignored
    wr_en    = 1'b1;
    rd       = 5'd3;
    rd_value = 32'hDEAD;
    issue_en = 1'b1;
    issue_rd = 5'd3;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("clr_bypass_off", rs1_value, 32'd0);
    n = 0;
    count_busy(n);
    wr_en    = 1'b0;
    issue_en = 1'b0;
    check_eq("clr_len_reset", n, 32'd32);
    #1;
    check_eq("x3_after_clr", rs1_value, 32'd0);
    check_eq("x3_pend_after_clr", {31'd0, rs1_pending}, 32'd0);

    // Write and read x5; x0 writes are dropped
    @(negedge clk);
    wr_en = 1'b1; rd = 5'd5; rd_value = 32'h1234_5678;
    @(negedge clk);
    rd = 5'd0; rd_value = 32'h0000_FFFF; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    check_eq("x5_read", rs1_value, 32'h1234_5678);
    check_eq("x0_no_bypass", rs2_value, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_eq("x0_read", rs2_value, 32'd0);

    // Bypass on both ports
    @(negedge clk);
    wr_en = 1'b1; rd = 5'd7; rd_value = 32'hA5A5_A5A5; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check_eq("byp_rs1", rs1_value, 32'hA5A5_A5A5);
    check_eq("byp_rs1_pend", {31'd0, rs1_pending}, 32'd0);
    check_eq("byp_rs2", rs2_value, 32'hA5A5_A5A5);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_eq("x7_stored", rs1_value, 32'hA5A5_A5A5);

    // Scoreboard on x9
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd9; rs2 = 5'd9;
    #1;
    check_eq("no_issue_bypass", {31'd0, rs2_pending}, 32'd0);
    @(negedge clk);
    issue_en = 1'b0;
    #1;
    check_eq("x9_pending", {31'd0, rs2_pending}, 32'd1);
    wr_en = 1'b1; rd = 5'd9; rd_value = 32'h42;
    #1;
    check_eq("x9_wb_pend", {31'd0, rs2_pending}, 32'd0);
    check_eq("x9_wb_val", rs2_value, 32'h42);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_eq("x9_after_pend", {31'd0, rs2_pending}, 32'd0);
    check_eq("x9_after_val", rs2_value, 32'h42);

    // Simultaneous write + issue to x4: data written, issue wins
    @(negedge clk);
    wr_en = 1'b1; issue_en = 1'b1; rd = 5'd4; issue_rd = 5'd4; rd_value = 32'h0BAD_F00D;
    rs1 = 5'd4;
    @(negedge clk);
    wr_en = 1'b0; issue_en = 1'b0;
    #1;
    check_eq("x4_val", rs1_value, 32'h0BAD_F00D);
    check_eq("x4_pend", {31'd0, rs1_pending}, 32'd1);
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    issue_en = 1'b0; rs2 = 5'd0;
    #1;
    check_eq("x0_pend", {31'd0, rs2_pending}, 32'd0);

    // Mid-operation clear with a second request while busy
    @(negedge clk);
    wr_en = 1'b1; issue_en = 1'b1; rd = 5'd6; issue_rd = 5'd6; rd_value = 32'd7;
    @(negedge clk);
    wr_en = 1'b0; issue_en = 1'b0; rs1 = 5'd6;
    #1;
    check_eq("x6_pre_val", rs1_value, 32'd7);
    check_eq("x6_pre_pend", {31'd0, rs1_pending}, 32'd1);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    clear_req = 1'b0;
    rs1 = 5'd4;
    check_eq("clr_busy_start", {31'd0, clear_busy}, 32'd1);
    check_eq("clr_read_zero", rs1_value, 32'd0);
    check_eq("clr_pend_zero", {31'd0, rs1_pending}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      n++;
    end
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    n++;
    clear_req = 1'b0;
    count_busy(n);
    check_eq("clr_len_req", n, 32'd33);
    rs1 = 5'd6; rs2 = 5'd4;
    #1;
    check_eq("x6_val_cleared", rs1_value, 32'd0);
    check_eq("x6_pend_cleared", {31'd0, rs1_pending}, 32'd0);
    check_eq("x4_pend_cleared", {31'd0, rs2_pending}, 32'd0);

    // rst at clear cycle 10 restarts the full sequence
    @(negedge clk);
    wr_en = 1'b1; rd = 5'd5; rd_value = 32'h1234_5678;
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", {31'd0, clear_busy}, 32'd1);
    #2;
    rst = 1'b0;
    n = 0;
    count_busy(n);
    check_eq("clr_len_restart", n, 32'd32);
    rs1 = 5'd5;
    #1;
    check_eq("x5_after_restart", rs1_value, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Next-generation integer register file for the RISC-V core: parametrised data width and register count.
- Two combinational read ports and one synchronous write port.
- Adds write-to-read bypass and a per-register pending (scoreboard) bit for in-flight writes.
- Adds a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (issue, reads) and writeback (write).

Parameters:
XLEN, 32, data width of each register and of all value ports
ADDR_W, 5, register index width; NREGS = 2**ADDR_W entries
ZERO_REG, 1, 1 = index 0 is hardwired zero (reads 0, never written, never pending); 0 = index 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clear_req  input  1  request a full array/scoreboard clear (sampled in IDLE only)
clear_busy  output  1  1 while the clear engine runs; core must stall
wr_en  input  1  writeback write enable
rd  input  ADDR_W  write index
rd_value  input  XLEN  write data
issue_en  input  1  instruction issued that will later write issue_rd
issue_rd  input  ADDR_W  destination index of issued instruction
rs1  input  ADDR_W  read index, port 1
rs1_value  output  XLEN  read data, port 1 (combinational)
rs1_pending  output  1  rs1 has an outstanding write (combinational)
rs2  input  ADDR_W  read index, port 2
rs2_value  output  XLEN  read data, port 2 (combinational)
rs2_pending  output  1  rs2 has an outstanding write (combinational)

Behaviour:
- Reset (async, rst=1): FSM -> CLEAR, clear index -> 0, all pending bits -> 0, clear_busy=1; rs1/rs2_value=0 and rs1/rs2_pending=0 while in CLEAR. Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to reg[idx] and idx increments. After writing idx=NREGS-1 (NREGS cycles after rst deassert), next state is IDLE, clear_busy=0, idx wraps to 0. With ZERO_REG=1, entry 0 may be skipped or written; it reads 0 either way.
  - IDLE: normal operation. clear_req=1 -> CLEAR on the next edge; all pending bits cleared at that same edge.
  - clear_req during CLEAR is ignored; the sequence does not restart.
- In CLEAR: wr_en and issue_en are ignored (no array or scoreboard update). Reads return 0, pending returns 0.
- rst asserted mid-clear or mid-operation: state reverts to CLEAR, idx=0, full sequence restarts.
- Write (IDLE, wr_en=1, and not (ZERO_REG and rd==0)): reg[rd] <= rd_value and pending[rd] <= 0 at the edge.
- Issue (IDLE, issue_en=1, and not (ZERO_REG and issue_rd==0)): pending[issue_rd] <= 1 at the edge.
- Same edge, write and issue to the same index: data is written AND pending ends 1 (issue wins: newer in-flight producer).
- Read rsN (IDLE):
  - ZERO_REG and rsN==0 -> value 0, pending 0.
  - Else if qualified write this cycle with rd==rsN -> value=rd_value (bypass), pending=0.
  - Else value=reg[rsN], pending=pending[rsN].
- Issue in the current cycle does not affect pending outputs until after the edge (no issue bypass).
- Both read ports are independent; rs1==rs2 is legal and yields identical outputs.
- Widths: all indices are exactly ADDR_W bits, so no out-of-range index exists. Values pass through unmodified, with no extension or truncation.

Test Plan:
- Reset/clear: pulse rst, hold wr_en=1 rd=3 rd_value=32'hDEAD during clear -> clear_busy=1 for exactly 32 cycles; then reading x3 returns 0.
- Write/read/x0: IDLE, write x5=32'h1234_5678, next cycle rs1=5 -> 32'h1234_5678; write x0=32'hFFFF -> rs2=0 reads 0 (ZERO_REG=1).
- Bypass: same cycle wr_en=1 rd=7 rd_value=32'hA5A5_A5A5 with rs1=7 -> rs1_value=32'hA5A5_A5A5 combinationally, rs1_pending=0.
- Scoreboard: issue_rd=9 -> next cycle rs2_pending=1; write x9=32'h42 -> same cycle rs2_pending=0 and rs2_value=32'h42; after the edge pending stays 0.
- Simultaneous write+issue to x4 -> after the edge rs1=4 gives the new data with rs1_pending=1. Issue to x0 -> pending for x0 stays 0.
- Mid-operation clear: set pending[6], write x6=7, assert clear_req, then clear_req again 3 cycles later -> one 32-cycle clear only; x6 reads 0 and pending=0 afterwards. Pulsing rst at clear cycle 10 restarts the full 32-cycle sequence.
